// File: rtl/load_store_unit.sv
// Sequential load/store unit: turns decoded memory controls into a single word-wide
// request/acknowledge bus access, with lane steering, load extension and fault pulses.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StReq, StDone, StFault} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] load_data_q, load_data_d;
    logic        lsu_done_q, lsu_done_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_err_q, bus_err_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;

    logic        legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    // Legality of the access presented in IDLE; a store wins when both strobes are high.
    always_comb begin
        legal = 1'b0;
        if (dm_write) begin
            case (funct3)
                3'b000:  legal = 1'b1;
                3'b001:  legal = ~addr[0];
                3'b010:  legal = (addr[1:0] == 2'b00);
                default: legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b100: legal = 1'b1;
                3'b001, 3'b101: legal = ~addr[0];
                3'b010:         legal = (addr[1:0] == 2'b00);
                default:        legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {addr[1], 1'b0};
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lane_d       = lane_q;
        f3_d         = f3_q;
        load_data_d  = load_data_q;
        lsu_done_d   = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;

        case (state_q)
            StIdle: begin
                if (dm_write || dm_read) begin
                    if (legal) begin
                        state_d     = StReq;
                        cnt_d       = 8'd0;
                        lane_d      = addr[1:0];
                        f3_d        = funct3;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dm_write;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = dm_write ? st_be : 4'b0000;
                        mem_wdata_d = dm_write ? st_wdata : 32'd0;
                    end else begin
                        state_d      = StFault;
                        misaligned_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (mem_ack) begin
                    state_d    = StDone;
                    mem_req_d  = 1'b0;
                    lsu_done_d = 1'b1;
                    if (!mem_we_q) begin
                        load_data_d = rd_ext;
                    end
                end else if (cnt_q + 8'd1 == TimeoutCnt) begin
                    state_d   = StFault;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    cnt_d     = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            lane_q       <= 2'd0;
            f3_q         <= 3'd0;
            load_data_q  <= 32'd0;
            lsu_done_q   <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_be_q     <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lane_q       <= lane_d;
            f3_q         <= f3_d;
            load_data_q  <= load_data_d;
            lsu_done_q   <= lsu_done_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
        end
    end

    assign lsu_stall  = ((state_q == StIdle) && (dm_read || dm_write)) ||
                        (state_q == StReq) || (state_q == StFault);
    assign load_data  = load_data_q;
    assign lsu_done   = lsu_done_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner cases plus random transactions checked
// against a byte-level reference model of the access rules.
module tb_load_store_unit;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] load_data;
    logic        lsu_stall;
    logic        lsu_done;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_load = 32'd0;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dm_read    (dm_read),
        .dm_write   (dm_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .lsu_stall  (lsu_stall),
        .lsu_done   (lsu_done),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // One complete access from request cycle through return to idle.
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int delay,
                       input logic [31:0] rdata, input bit withhold);
        int          sz;
        int          off;
        int          reqs;
        bit          st;
        bit          legal;
        bit          got_ack;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] raw;
        logic [31:0] ld;

        st  = wr;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(a % 4);
        if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                        (f3 == 3'd4) || (f3 == 3'd5);
        legal = legal && ((a % sz) == 0);
        be = st ? 4'(((1 << sz) - 1) << off) : 4'b0000;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % sz) +: 8];
        raw = rdata >> (8 * off);
        if (sz == 1) begin
            ld = raw & 32'hff;
            if (!f3[2] && ld[7]) ld = ld | 32'hffff_ff00;
        end else if (sz == 2) begin
            ld = raw & 32'hffff;
            if (!f3[2] && ld[15]) ld = ld | 32'hffff_0000;
        end else begin
            ld = rdata;
        end

        dm_read = rd; dm_write = wr; funct3 = f3; addr = a; store_data = d;
        #1;
        chk("stall_c0", 32'(lsu_stall), 32'd1);
        chk("req_c0", 32'(mem_req), 32'd0);
        nxt();
        dm_read = 1'b0; dm_write = 1'b0; addr = $urandom; store_data = $urandom;

        if (!legal) begin
            #1;
            chk("misaligned", 32'(misaligned), 32'd1);
            chk("mis_req", 32'(mem_req), 32'd0);
            chk("mis_done", 32'(lsu_done), 32'd0);
            chk("mis_stall", 32'(lsu_stall), 32'd1);
            nxt();
            chk("mis_clear", 32'(misaligned), 32'd0);
            chk("mis_idle_stall", 32'(lsu_stall), 32'd0);
            chk("mis_req2", 32'(mem_req), 32'd0);
            chk("mis_ld_keep", load_data, last_load);
            return;
        end

        reqs = 0;
        got_ack = 0;
        for (int k = 0; k < int'(TIMEOUT) + 4; k++) begin
            if (!withhold && k == delay) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
            #1;
            if (mem_req !== 1'b1) break;
            reqs++;
            chk("req_stall", 32'(lsu_stall), 32'd1);
            if (k == 0) begin
                chk("mem_we", 32'(mem_we), 32'(st));
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_be", 32'(mem_be), 32'(be));
                if (st) chk("mem_wdata", mem_wdata, wd);
            end
            if (mem_ack) got_ack = 1;
            nxt();
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (got_ack) break;
        end
        mem_ack = 1'b0;
        #1;

        if (!withhold) begin
            chk("req_cycles", 32'(reqs), 32'(delay + 1));
            chk("done", 32'(lsu_done), 32'd1);
            chk("done_stall", 32'(lsu_stall), 32'd0);
            chk("done_req", 32'(mem_req), 32'd0);
            chk("done_berr", 32'(bus_err), 32'd0);
            if (!st) last_load = ld;
            chk("load_data", load_data, last_load);
        end else begin
            chk("to_cycles", 32'(reqs), 32'(TIMEOUT));
            chk("bus_err", 32'(bus_err), 32'd1);
            chk("to_done", 32'(lsu_done), 32'd0);
            chk("to_stall", 32'(lsu_stall), 32'd1);
            chk("to_ld_keep", load_data, last_load);
            nxt();
            mem_ack = 1'b1;
            mem_rdata = $urandom;
            #1;
            chk("late_ack_req", 32'(mem_req), 32'd0);
            nxt();
            mem_ack = 1'b0;
            #1;
            chk("late_ack_done", 32'(lsu_done), 32'd0);
            chk("late_ack_ld", load_data, last_load);
        end
        nxt();
        chk("idle_done", 32'(lsu_done), 32'd0);
        chk("idle_berr", 32'(bus_err), 32'd0);
        chk("idle_stall", 32'(lsu_stall), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(lsu_done), 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        nxt();
        rst_n = 1'b1;
        nxt();

        // SB to the top lane.
        txn(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h1234_56ab, 0, 32'd0, 1'b0);
        // LH / LHU / LB extraction.
        txn(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 0, 32'h8001_1234, 1'b0);
        txn(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 0, 32'h8001_1234, 1'b0);
        txn(1'b1, 1'b0, 3'b000, 32'h0000_2000, 32'd0, 0, 32'h8001_1234, 1'b0);
        // Misaligned LW and illegal store size.
        txn(1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'd0, 0, 32'd0, 1'b0);
        txn(1'b0, 1'b1, 3'b011, 32'h0000_4000, 32'hdead_beef, 0, 32'd0, 1'b0);
        // Timeout with late ack afterwards.
        txn(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 0, 32'd0, 1'b1);
        // SW with three wait cycles.
        txn(1'b0, 1'b1, 3'b010, 32'h0000_6004, 32'hcafe_f00d, 3, 32'd0, 1'b0);
        // Ack in the cycle the counter would reach the limit.
        txn(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'd0, int'(TIMEOUT) - 1, 32'h0bad_f00d, 1'b0);
        // Both strobes high behaves as a store.
        txn(1'b1, 1'b1, 3'b001, 32'h0000_8002, 32'h0000_a5c3, 1, 32'h1111_1111, 1'b0);

        // Reset asserted mid-REQ.
        dm_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_9000;
        nxt();
        dm_read = 1'b0;
        nxt();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_stall", 32'(lsu_stall), 32'd0);
        last_load = 32'd0;
        chk("rst_mid_ld", load_data, last_load);
        #2;
        rst_n = 1'b1;
        nxt();
        txn(1'b1, 1'b0, 3'b010, 32'h0000_a000, 32'd0, 0, 32'h7654_3210, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic r;
            logic w;
            r = 1'($urandom % 2);
            w = r ? 1'($urandom % 2) : 1'b1;
            txn(r, w, 3'($urandom % 8), $urandom, $urandom, int'($urandom % 4), $urandom,
                1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store unit that consumes the decoder's memory-control outputs (`dm_read`, `dm_write`, `funct3`) and executes the access on a word-wide request/acknowledge data-memory bus. It sits between the execute stage and data memory. It generates byte enables, replicates store data across lanes, and extracts and extends load data. It also stalls the core for the duration of each access and flags misaligned or timed-out accesses.

## Interface
- `TIMEOUT`, 16: cycles in REQ without `mem_ack` before abort (legal range 2–255).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `dm_read`  in  1  load request from control unit.
- `dm_write`  in  1  store request from control unit.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address from ALU.
- `store_data`  in  32  rs2 value.
- `load_data`  out  32  extended load result, valid while `lsu_done`=1.
- `lsu_stall`  out  1  core must hold its pipeline.
- `lsu_done`  out  1  one-cycle completion pulse.
- `misaligned`  out  1  one-cycle pulse: misaligned or illegal funct3, no bus access.
- `bus_err`  out  1  one-cycle pulse: timeout abort.
- `mem_req`  out  1  bus request, held until ack.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables (writes only; 0000 on reads).
- `mem_ack`  in  1  bus completion; read data valid same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, DONE, FAULT.
- IDLE: if `dm_write` or `dm_read`, capture addr/funct3/store_data/type at clock edge. Both high is a store; the load is ignored.
- Legality check at capture:
  - H/HU needs `addr[0]`=0. W needs `addr[1:0]`=00.
  - Stores accept only funct3 000/001/010. Loads accept 000/001/010/100/101.
  - Illegal → FAULT with `misaligned`=1. Otherwise → REQ.
- REQ:
  - `mem_req`=1 with `mem_we`/`mem_addr`/`mem_wdata`/`mem_be` stable from registers.
  - On `mem_ack` → DONE. Loads register the extracted result.
  - Counter increments each REQ cycle without ack. On reaching `TIMEOUT` → FAULT with `bus_err`=1. `mem_req` deasserts the same edge.
- DONE: `lsu_done`=1 for one cycle → IDLE. A new request present in this cycle is not sampled until IDLE.
- FAULT: the `misaligned`/`bus_err` pulse is output for one cycle → IDLE. `load_data` is unchanged and `lsu_done` stays 0.
- Store lanes:
  - SB: `mem_be`=0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: `mem_be`=0011<<{addr[1],0}, wdata={2{d[15:0]}}.
  - SW: 1111, wdata=d.
- Load extract:
  - Byte lane addr[1:0], halfword lane addr[1].
  - B/H sign-extend. BU/HU zero-extend. W passes through.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset (async assert): state IDLE, counter 0. All outputs 0 except `lsu_stall`, which is combinational. `mem_req` drops immediately, mid-transaction included; the partial transaction is discarded.
- `lsu_stall` = (IDLE & (`dm_read`|`dm_write`)) | REQ | FAULT. It is 0 in DONE and when IDLE with no request.
- Minimum load/store latency: request cycle 0 → `mem_req` cycle 1 → ack cycle 1 → `lsu_done` cycle 2.
- Each extra wait cycle before ack adds one cycle.
- Misaligned access: `misaligned` in cycle 1, `mem_req` never asserted.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then `bus_err` pulses in the next cycle.
- Ack arriving in the same cycle the counter reaches `TIMEOUT`: ack wins, normal DONE.
- All outputs except `lsu_stall` are registered.

## Test plan
- SB, addr 0x0000_1003, store_data 0x1234_56AB, ack in cycle 1 → `mem_be`=1000, `mem_wdata`=0xABAB_ABAB, `mem_addr`=0x0000_1000, `mem_we`=1, `lsu_done` in cycle 2.
- LH at 0x2002 with `mem_rdata`=0x8001_1234 → `load_data`=0xFFFF_8001. LHU at the same address → 0x0000_8001. LB at 0x2000 → 0x0000_0034.
- LW at 0x4001 → `misaligned` pulse in cycle 1, `mem_req` stays 0, `lsu_done` 0. Store with funct3=011 → same response.
- Load with ack withheld → `mem_req` high exactly 16 cycles, then `bus_err` pulse. A late ack afterwards is ignored.
- Ack delayed by 3 cycles on SW → `mem_req` high 4 cycles, `lsu_stall` high cycles 0–4, `lsu_done` in cycle 5.
- Assert `rst_n`=0 mid-REQ → `mem_req` low before the next clock edge. After release, state is IDLE and a new LW completes normally.
